// File: rtl/imem_pkg.sv
// Shared types and widths for the byte-addressed instruction memory and its fetch unit.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int INSTR_BYTES = 10;
  localparam int INSTR_W     = INSTR_BYTES * 8;
  localparam int ADDR_W      = 64;

endpackage

// File: rtl/imem_fetch_if.sv
// Program-load stream and fetch request/response bundle for imem_fetch_unit.
interface imem_fetch_if;
  import imem_pkg::*;

  logic                ld_valid;
  logic [ADDR_W-1:0]   ld_addr;
  logic [7:0]          ld_data;
  logic                ld_ready;
  logic                ld_err;

  logic                req_valid;
  logic [ADDR_W-1:0]   req_pc;
  logic                req_ready;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [ADDR_W-1:0]   rsp_pc;
  logic [0:INSTR_W-1]  instr;
  logic                imem_error;

  modport master (
    output ld_valid, ld_addr, ld_data, req_valid, req_pc, rsp_ready,
    input  ld_ready, ld_err, req_ready, rsp_valid, rsp_pc, instr, imem_error
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, req_valid, req_pc, rsp_ready,
    output ld_ready, ld_err, req_ready, rsp_valid, rsp_pc, instr, imem_error
  );

endinterface

// File: rtl/imem_byte_ram.sv
// Byte-wide memory: synchronous write, combinational read. Contents survive reset.
module imem_byte_ram #(
  parameter int MEM_BYTES = 2048,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with byte-stream program load and a 10-byte windowed fetch port.
// In-range fetch answers 10 cycles after acceptance (one byte per cycle), out-of-range after 1.
module imem_fetch_unit #(
  parameter int MEM_BYTES   = 2048,
  parameter int INSTR_BYTES = 10
) (
  input  logic         clk,
  input  logic         rst,
  imem_fetch_if.slave  bus
);
  import imem_pkg::*;

  localparam int          AW      = $clog2(MEM_BYTES);
  localparam logic [3:0]  K_LAST  = 4'(INSTR_BYTES - 1);

  state_e              state_q, state_d;
  logic [3:0]          k_q, k_d;
  logic [ADDR_W-1:0]   rsp_pc_q, rsp_pc_d;
  logic [0:INSTR_W-1]  instr_q, instr_d;
  logic                imem_error_q, imem_error_d;
  logic                ld_err_q, ld_err_d;

  logic                ld_fire;
  logic                ld_in_range;
  logic                req_rdy;
  logic                req_fire;
  logic                req_oob;
  logic [AW-1:0]       rd_addr;
  logic [7:0]          rd_data;

  assign ld_fire     = bus.ld_valid && (state_q == IDLE);
  assign ld_in_range = bus.ld_addr < ADDR_W'(MEM_BYTES);
  assign req_rdy     = (state_q == IDLE) && !bus.ld_valid;
  assign req_fire    = bus.req_valid && req_rdy;
  // 65-bit sum so a PC near 2^64 cannot wrap back into range
  assign req_oob     = ({1'b0, bus.req_pc} + 65'(INSTR_BYTES - 1)) >= 65'(MEM_BYTES);
  assign rd_addr     = rsp_pc_q[AW-1:0] + AW'(k_q);

  imem_byte_ram #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ld_fire && ld_in_range),
    .waddr (bus.ld_addr[AW-1:0]),
    .wdata (bus.ld_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      rsp_pc_q     <= '0;
      instr_q      <= '0;
      imem_error_q <= 1'b0;
      ld_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      rsp_pc_q     <= rsp_pc_d;
      instr_q      <= instr_d;
      imem_error_q <= imem_error_d;
      ld_err_q     <= ld_err_d;
    end
  end

  // An out-of-range window enters READ at its final slot with capture disabled,
  // so its response appears one cycle after acceptance with instr still zero.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          state_d = READ;
          k_d     = req_oob ? K_LAST : 4'd0;
        end
      end
      READ: begin
        if (k_q == K_LAST) begin
          state_d = RESP;
          k_d     = 4'd0;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = 4'd0;
      end
    endcase
  end

  always_comb begin
    rsp_pc_d     = rsp_pc_q;
    instr_d      = instr_q;
    imem_error_d = imem_error_q;
    ld_err_d     = ld_fire && !ld_in_range;
    if (req_fire) begin
      rsp_pc_d     = bus.req_pc;
      instr_d      = '0;
      imem_error_d = req_oob;
    end else if ((state_q == READ) && !imem_error_q) begin
      instr_d[{k_q, 3'b000} +: 8] = rd_data;
    end
  end

  assign bus.ld_ready   = (state_q == IDLE);
  assign bus.ld_err     = ld_err_q;
  assign bus.req_ready  = req_rdy;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_pc     = rsp_pc_q;
  assign bus.instr      = instr_q;
  assign bus.imem_error = imem_error_q;

endmodule
